// File: rtl/f2sdram_burst_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst port between N_REQ masters.
// Write bursts are kept whole; read beats return to requesters in issue order.
module f2sdram_burst_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_W     = 4,
  parameter int MAX_RD_PEND = 8,
  parameter int ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int PTR_W       = (MAX_RD_PEND > 1) ? $clog2(MAX_RD_PEND) : 1,
  parameter int PEND_W      = PTR_W + 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [N_REQ*ADDR_W-1:0]   s_address,
  input  logic [N_REQ*BURST_W-1:0]  s_burstcount,
  input  logic [N_REQ-1:0]          s_read,
  input  logic [N_REQ-1:0]          s_write,
  input  logic [N_REQ*DATA_W-1:0]   s_writedata,
  input  logic [N_REQ*DATA_W/8-1:0] s_byteenable,
  output logic [N_REQ-1:0]          s_waitrequest,
  output logic [DATA_W-1:0]         s_readdata,
  output logic [N_REQ-1:0]          s_readdatavalid,
  output logic [ADDR_W-1:0]         m_address,
  output logic [BURST_W-1:0]        m_burstcount,
  output logic                      m_read,
  output logic                      m_write,
  output logic [DATA_W-1:0]         m_writedata,
  output logic [DATA_W/8-1:0]       m_byteenable,
  input  logic                      m_waitrequest,
  input  logic [DATA_W-1:0]         m_readdata,
  input  logic                      m_readdatavalid,
  output logic [1:0]                dbg_state,
  output logic [PEND_W-1:0]         dbg_rd_pend
);

  // Handshake: a command or write beat transfers on a cycle where it is
  // asserted and waitrequest is low; read beats have no back-pressure.
  typedef enum logic [1:0] {IDLE = 2'd0, RD_CMD = 2'd1, WR_BURST = 2'd2} state_t;

  localparam int BE_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_q;
  logic [ID_W-1:0]     rr_q;
  logic [BURST_W-1:0]  wr_cnt_q;

  logic [ID_W-1:0]     fifo_id [MAX_RD_PEND];
  logic [BURST_W-1:0]  fifo_bc [MAX_RD_PEND];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PEND_W-1:0]   fifo_cnt_q;
  logic [BURST_W-1:0]  rd_beat_q;

  logic [BURST_W-1:0]  g_bc_raw, g_bc;
  logic                g_read, g_write;
  logic                fifo_full, fifo_empty;
  logic                arb_found, arb_is_wr;
  logic [ID_W-1:0]     arb_idx;
  logic                cmd_acc, wr_acc, wr_last;
  logic                rd_beat_ok, rd_last;
  logic [ID_W-1:0]     head_id;
  logic [BURST_W-1:0]  head_bc;
  logic [ID_W-1:0]     rr_next;

  assign g_bc_raw  = s_burstcount[int'(grant_q)*BURST_W +: BURST_W];
  assign g_bc      = (g_bc_raw == '0) ? BURST_W'(1) : g_bc_raw;
  assign g_read    = s_read[grant_q];
  assign g_write   = s_write[grant_q];

  assign m_address    = s_address[int'(grant_q)*ADDR_W +: ADDR_W];
  assign m_burstcount = g_bc;
  assign m_writedata  = s_writedata[int'(grant_q)*DATA_W +: DATA_W];
  assign m_byteenable = s_byteenable[int'(grant_q)*BE_W +: BE_W];
  assign s_readdata   = m_readdata;

  assign fifo_full  = (fifo_cnt_q == PEND_W'(MAX_RD_PEND));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_id    = fifo_id[rd_ptr_q];
  assign head_bc    = fifo_bc[rd_ptr_q];

  assign cmd_acc    = (state_q == RD_CMD) && g_read && !m_waitrequest;
  assign wr_acc     = (state_q == WR_BURST) && g_write && !m_waitrequest;
  // wr_cnt_q == 0 means the burst has not started yet; otherwise it holds beats left.
  assign wr_last    = wr_acc && (((wr_cnt_q == '0) && (g_bc == BURST_W'(1))) ||
                                 (wr_cnt_q == BURST_W'(1)));
  assign rd_beat_ok = m_readdatavalid && !fifo_empty;
  assign rd_last    = rd_beat_ok && (rd_beat_q == head_bc - BURST_W'(1));
  assign rr_next    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  assign dbg_state   = state_q;
  assign dbg_rd_pend = fifo_cnt_q;

  // Rotating priority scan; a read only competes while the tracking FIFO has room.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_is_wr = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!arb_found && (s_write[idx] || (s_read[idx] && !fifo_full))) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(idx);
        arb_is_wr = s_write[idx];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arb_found) state_d = arb_is_wr ? WR_BURST : RD_CMD;
      RD_CMD:   if (cmd_acc)   state_d = IDLE;
      WR_BURST: if (wr_last)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    s_waitrequest   = '1;
    s_readdatavalid = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    case (state_q)
      RD_CMD: begin
        s_waitrequest[grant_q] = m_waitrequest;
        m_read                 = g_read;
      end
      WR_BURST: begin
        s_waitrequest[grant_q] = m_waitrequest;
        m_write                = g_write;
      end
      default: ;
    endcase
    if (!fifo_empty) s_readdatavalid[head_id] = m_readdatavalid;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      grant_q    <= '0;
      rr_q       <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      rd_beat_q  <= '0;
    end else begin
      if ((state_q == IDLE) && arb_found) grant_q <= arb_idx;
      if (cmd_acc || wr_last) rr_q <= rr_next;

      if (wr_last)                wr_cnt_q <= '0;
      else if (wr_acc) begin
        if (wr_cnt_q == '0)       wr_cnt_q <= g_bc - BURST_W'(1);
        else                      wr_cnt_q <= wr_cnt_q - BURST_W'(1);
      end

      if (cmd_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_last) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + PEND_W'(cmd_acc) - PEND_W'(rd_last);

      if (rd_last)         rd_beat_q <= '0;
      else if (rd_beat_ok) rd_beat_q <= rd_beat_q + BURST_W'(1);
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk_clk) begin
    if (cmd_acc) begin
      fifo_id[wr_ptr_q] <= grant_q;
      fifo_bc[wr_ptr_q] <= g_bc;
    end
  end

endmodule

// File: tb/tb_f2sdram_burst_arbiter.sv
// Directed bench for f2sdram_burst_arbiter: arbitration order, burst integrity,
// read-return routing, read-FIFO back-pressure and mid-burst reset.
module tb_f2sdram_burst_arbiter;

  localparam int N = 2, AW = 32, DW = 64, BW = 4, PEND = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic [N*AW-1:0]   s_address = '0;
  logic [N*BW-1:0]   s_burstcount = '0;
  logic [N-1:0]      s_read = '0;
  logic [N-1:0]      s_write = '0;
  logic [N*DW-1:0]   s_writedata = '0;
  logic [N*DW/8-1:0] s_byteenable = '0;
  logic [N-1:0]      s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic [N-1:0]      s_readdatavalid;
  logic [AW-1:0]     m_address;
  logic [BW-1:0]     m_burstcount;
  logic              m_read, m_write;
  logic [DW-1:0]     m_writedata;
  logic [DW/8-1:0]   m_byteenable;
  logic              m_waitrequest = 1'b0;
  logic [DW-1:0]     m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_rd_pend;

  int n_cmp = 0;
  int n_err = 0;

  f2sdram_burst_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW),
                          .MAX_RD_PEND(PEND)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_address(m_address),
    .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .dbg_state(dbg_state),
    .dbg_rd_pend(dbg_rd_pend)
  );

  // clock / watchdog
  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                         input logic rd, input logic wr, input logic [DW-1:0] wd);
    s_address[i*AW +: AW]     = a;
    s_burstcount[i*BW +: BW]  = bc;
    s_read[i]                 = rd;
    s_write[i]                = wr;
    s_writedata[i*DW +: DW]   = wd;
    s_byteenable[i*8 +: 8]    = '1;
  endtask

  task automatic set_wd(input int i, input logic [DW-1:0] wd);
    s_writedata[i*DW +: DW] = wd;
  endtask

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt0, cnt1, reads, guard;

    // 1. reset held 3 cycles
    repeat (3) tick();
    chk("rst_waitreq", s_waitrequest, 2'b11);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_rdvalid", s_readdatavalid, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_pend", dbg_rd_pend, 0);
    reset_reset = 1'b0;

    // 2. req0 4-beat write while req1 wants to write
    set_req(0, 32'h1000, 4, 0, 1, 64'hA0);
    set_req(1, 32'h2000, 2, 0, 1, 64'hB0);
    #1;
    chk("t2_idle_waitreq", s_waitrequest, 2'b11);
    chk("t2_idle_m_write", m_write, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_wd(0, 64'hA0 + 64'(b));
      #1;
      chk("t2_r0_m_write", m_write, 1);
      chk("t2_r0_waitreq", s_waitrequest, 2'b10);
      chk("t2_r0_addr", m_address, 32'h1000);
      chk("t2_r0_bc", m_burstcount, 4);
      chk("t2_r0_wdata", m_writedata, 64'hA0 + 64'(b));
      tick();
    end
    s_write[0] = 1'b0;
    #1;
    chk("t2_gap_m_write", m_write, 0);
    chk("t2_gap_state", dbg_state, 0);
    tick();
    #1;
    chk("t2_r1_waitreq", s_waitrequest, 2'b01);
    chk("t2_r1_addr", m_address, 32'h2000);
    chk("t2_r1_wdata", m_writedata, 64'hB0);
    tick();
    set_wd(1, 64'hB1);
    #1;
    chk("t2_r1_beat1", m_writedata, 64'hB1);
    tick();
    s_write[1] = 1'b0;
    #1;
    chk("t2_end_state", dbg_state, 0);

    // 3. both read continuously, burstcount 2: grants alternate
    set_req(0, 32'h100, 2, 1, 0, 0);
    set_req(1, 32'h200, 2, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("t3_idle_m_read", m_read, 0);
      tick();
      #1;
      chk("t3_grant", s_waitrequest, (r % 2 == 0) ? 2'b10 : 2'b01);
      chk("t3_addr", m_address, (r % 2 == 0) ? 32'h100 : 32'h200);
      chk("t3_m_read", m_read, 1);
      tick();
    end
    s_read = '0;
    #1;
    chk("t3_pend4", dbg_rd_pend, 4);
    cnt0 = 0;
    cnt1 = 0;
    for (int b = 0; b < 8; b++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 64'hC0 + 64'(b);
      #1;
      chk("t3_route", s_readdatavalid, ((b / 2) % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_rdata", s_readdata, 64'hC0 + 64'(b));
      cnt0 += int'(s_readdatavalid[0]);
      cnt1 += int'(s_readdatavalid[1]);
      tick();
    end
    m_readdatavalid = 1'b0;
    #1;
    chk("t3_cnt0", 64'(cnt0), 4);
    chk("t3_cnt1", 64'(cnt1), 4);
    chk("t3_pend0", dbg_rd_pend, 0);

    // 4. fill the read FIFO, 9th read stalls, a write still proceeds
    set_req(0, 32'h3000, 1, 1, 0, 0);
    reads = 0;
    guard = 0;
    while (reads < 8 && guard < 40) begin
      #1;
      if (m_read && s_waitrequest == 2'b10) reads++;
      tick();
      guard++;
    end
    chk("t4_reads_issued", 64'(reads), 8);
    #1;
    chk("t4_pend_full", dbg_rd_pend, 8);
    for (int c = 0; c < 3; c++) begin
      chk("t4_stall_m_read", m_read, 0);
      chk("t4_stall_waitreq", s_waitrequest[0], 1);
      tick();
    end
    set_req(1, 32'h3800, 1, 0, 1, 64'hD1);
    #1;
    tick();
    #1;
    chk("t4_wr_m_write", m_write, 1);
    chk("t4_wr_waitreq", s_waitrequest, 2'b01);
    chk("t4_wr_addr", m_address, 32'h3800);
    tick();
    s_write[1]      = 1'b0;
    m_readdatavalid = 1'b1;
    m_readdata      = 64'hE0;
    #1;
    chk("t4_first_ret", s_readdatavalid, 2'b01);
    chk("t4_still_stall", m_read, 0);
    tick();
    m_readdatavalid = 1'b0;
    #1;
    chk("t4_pend7", dbg_rd_pend, 7);
    tick();
    #1;
    chk("t4_9th_read", m_read, 1);
    chk("t4_9th_waitreq", s_waitrequest, 2'b10);
    tick();
    s_read[0] = 1'b0;
    #1;
    chk("t4_pend_refill", dbg_rd_pend, 8);
    for (int b = 0; b < 8; b++) begin
      m_readdatavalid = 1'b1;
      #1;
      chk("t4_drain_route", s_readdatavalid, 2'b01);
      tick();
    end
    m_readdatavalid = 1'b0;
    #1;
    chk("t4_drained", dbg_rd_pend, 0);
    m_readdatavalid = 1'b1;
    #1;
    chk("t4_orphan_beat", s_readdatavalid, 2'b00);
    tick();
    m_readdatavalid = 1'b0;
    #1;
    chk("t4_orphan_pend", dbg_rd_pend, 0);

    // 5. waitrequest stall mid-burst with req1 pending
    set_req(0, 32'h4000, 4, 0, 1, 64'hF0);
    #1;
    tick();
    set_req(1, 32'h4800, 1, 0, 1, 64'h99);
    #1;
    chk("t5_b0_waitreq", s_waitrequest, 2'b10);
    chk("t5_b0_wdata", m_writedata, 64'hF0);
    tick();
    set_wd(0, 64'hF1);
    #1;
    chk("t5_b1_wdata", m_writedata, 64'hF1);
    tick();
    m_waitrequest = 1'b1;
    set_wd(0, 64'hF2);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_stall_waitreq", s_waitrequest, 2'b11);
      chk("t5_stall_wdata", m_writedata, 64'hF2);
      chk("t5_stall_addr", m_address, 32'h4000);
      chk("t5_stall_state", dbg_state, 2);
      tick();
    end
    m_waitrequest = 1'b0;
    #1;
    chk("t5_b2_waitreq", s_waitrequest, 2'b10);
    chk("t5_b2_wdata", m_writedata, 64'hF2);
    tick();
    set_wd(0, 64'hF3);
    #1;
    chk("t5_b3_wdata", m_writedata, 64'hF3);
    tick();
    s_write[0] = 1'b0;
    #1;
    chk("t5_gap_m_write", m_write, 0);
    tick();
    #1;
    chk("t5_r1_waitreq", s_waitrequest, 2'b01);
    chk("t5_r1_wdata", m_writedata, 64'h99);
    tick();
    s_write[1] = 1'b0;

    // 6. reset during 3-of-8-beat write with a read outstanding, rr at 1
    set_req(0, 32'h5000, 2, 1, 0, 0);
    #1;
    tick();
    #1;
    chk("t6_rd_cmd", m_read, 1);
    tick();
    s_read[0] = 1'b0;
    set_req(1, 32'h6000, 8, 0, 1, 64'h60);
    #1;
    chk("t6_pend1", dbg_rd_pend, 1);
    tick();
    for (int b = 0; b < 3; b++) begin
      set_wd(1, 64'h60 + 64'(b));
      #1;
      chk("t6_wr_waitreq", s_waitrequest, 2'b01);
      tick();
    end
    reset_reset = 1'b1;
    #1;
    tick();
    reset_reset     = 1'b0;
    s_write         = '0;
    m_readdatavalid = 1'b1;
    #1;
    chk("t6_rst_state", dbg_state, 0);
    chk("t6_rst_pend", dbg_rd_pend, 0);
    chk("t6_rst_waitreq", s_waitrequest, 2'b11);
    chk("t6_late_beat", s_readdatavalid, 2'b00);
    chk("t6_rst_m_write", m_write, 0);
    tick();
    m_readdatavalid = 1'b0;
    set_req(0, 32'h7000, 1, 0, 1, 64'h70);
    set_req(1, 32'h7800, 1, 0, 1, 64'h78);
    #1;
    tick();
    #1;
    chk("t6_rr0_grant", s_waitrequest, 2'b10);
    chk("t6_rr0_addr", m_address, 32'h7000);
    tick();
    s_write = '0;

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
